div_issue: RTL

Execute-stage controller that drives the iterative divider unit's request/ready interface on behalf of the pipeline. It accepts a decoded RV32M divide/remainder instruction, resolves the ISA special cases (divide-by-zero, signed overflow) locally, issues other operations to the divider, stalls the pipeline while the result is outstanding, and arbitrates the result onto the register-file write port against the ALU writeback.

---
 rtl/div_issue.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/div_issue.sv
// Execute-stage front end for the iterative divider: resolves RV32M corner cases
// locally, sequences the divider handshake and arbitrates the result onto the write port.
module div_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid_i,
    input  logic [2:0]  ex_op_code_i,
    input  logic [31:0] ex_data1_i,
    input  logic [31:0] ex_data2_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        div_req_o,
    output logic [2:0]  div_op_code_o,
    output logic [31:0] div_data1_o,
    output logic [31:0] div_data2_o,
    output logic [4:0]  div_reg_wr_addr_o,
    input  logic        div_busy_i,
    input  logic        div_res_ready_i,
    input  logic [31:0] div_res_i,
    input  logic        wb_alu_we_i,
    output logic        div_wb_we_o,
    output logic [4:0]  div_wb_addr_o,
    output logic [31:0] div_wb_data_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_WB    = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state_r;
    logic        accept_s;
    logic        issue_s;
    logic        write_s;
    logic        fast_s;
    logic [31:0] fast_res_s;

    // Returns {fast, result}: divide-by-zero, signed overflow and non-divide funct3
    // never reach the divider.
    function automatic logic [32:0] resolve_special(input logic [2:0]  op,
                                                    input logic [31:0] a,
                                                    input logic [31:0] b);
        logic [32:0] r;
        r = {1'b0, 32'h0000_0000};
        if (!op[2]) begin
            r = {1'b1, 32'h0000_0000};
        end else if (b == 32'h0000_0000) begin
            r = op[1] ? {1'b1, a} : {1'b1, 32'hFFFF_FFFF};
        end else if (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            r = op[1] ? {1'b1, 32'h0000_0000} : {1'b1, 32'h8000_0000};
        end else begin
            r = {1'b0, 32'h0000_0000};
        end
        return r;
    endfunction

    assign {fast_s, fast_res_s} = resolve_special(ex_op_code_i, ex_data1_i, ex_data2_i);
    assign accept_s    = (state_r == S_IDLE) && ex_div_valid_i && !flush_i;
    assign issue_s     = (state_r == S_REQ) && !div_busy_i;
    assign write_s     = (state_r == S_WB) && !wb_alu_we_i && !flush_i;
    assign div_req_o   = issue_s;
    assign div_wb_we_o = write_s;
    assign div_wb_addr_o = div_reg_wr_addr_o;

    // Pipeline hold: released in the write cycle so the instruction leaves EX exactly once.
    always_comb begin
        stall_o = 1'b0;
        case (state_r)
            S_IDLE:  stall_o = accept_s;
            S_REQ:   stall_o = 1'b1;
            S_WAIT:  stall_o = 1'b1;
            S_WB:    stall_o = !write_s;
            S_DRAIN: stall_o = ex_div_valid_i;
            default: stall_o = 1'b0;
        endcase
    end

    // Control FSM with the operand and result buffers; flush outranks ready and writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= S_IDLE;
            div_op_code_o     <= 3'b000;
            div_data1_o       <= 32'h0000_0000;
            div_data2_o       <= 32'h0000_0000;
            div_reg_wr_addr_o <= 5'd0;
            div_wb_data_o     <= 32'h0000_0000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        div_op_code_o     <= ex_op_code_i;
                        div_data1_o       <= ex_data1_i;
                        div_data2_o       <= ex_data2_i;
                        div_reg_wr_addr_o <= ex_rd_addr_i;
                        if (fast_s) begin
                            div_wb_data_o <= fast_res_s;
                            state_r       <= S_WB;
                        end else begin
                            state_r <= S_REQ;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (flush_i) begin
                        state_r <= issue_s ? S_DRAIN : S_IDLE;
                    end else if (issue_s) begin
                        state_r <= S_WAIT;
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_WAIT: begin
                    // A result arriving with the flush is already consumed, so no drain is needed.
                    if (flush_i) begin
                        state_r <= div_res_ready_i ? S_IDLE : S_DRAIN;
                    end else if (div_res_ready_i) begin
                        div_wb_data_o <= div_res_i;
                        state_r       <= S_WB;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_WB: begin
                    if (flush_i || !wb_alu_we_i) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_WB;
                    end
                end
                S_DRAIN: begin
                    state_r <= div_res_ready_i ? S_IDLE : S_DRAIN;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
